video_timing_recovery: RTL
==========================

Name: video_timing_recovery

Overview:
Receive-side counterpart of the video pixel/sync generator. Observes an incoming pixel stream qualified only by a data-enable flag. Measures active/total line and frame geometry and verifies it stays stable over consecutive frames. Once locked, emits a one-clock frame-start pulse (oPixelSync) that drives the sync input of the local timing generator, so local pixel (0,0) coincides with the first active pixel of each received frame.

Parameters:
H_MAX, 2048, max supported pixel periods per line; sizes horizontal counters (CLOG2(H_MAX)+1 bits).
V_MAX, 2048, max supported lines per frame; sizes vertical counters (CLOG2(V_MAX)+1 bits).
LOCK_FRAMES, 2, consecutive identical frame measurements required to lock (1..15).

Ports:
iClk  input  1  system clock
iRst  input  1  reset
iPixelEn  input  1  pixel-period strobe; iDe sampled only when high
iDe  input  1  data enable of received stream (high = active pixel)
oPixelSync  output  1  one-clock frame-start pulse, only while locked
oLocked  output  1  geometry stable and tracking
oLockLost  output  1  one-clock pulse on LOCKED -> ACQUIRE
oHactive  output  CLOG2(H_MAX)+1  measured active pixels per line
oHtotal  output  CLOG2(H_MAX)+1  measured pixel periods per line
oVactive  output  CLOG2(V_MAX)+1  measured active lines per frame
oVtotal  output  CLOG2(V_MAX)+1  measured total lines per frame

Behaviour:
- Reset: iRst is asynchronous and active-high; the clock is iClk. All outputs and counters are 0, oLocked 0, state SEARCH.
- All counting advances only on iPixelEn samples. deRise = iPixelEn & iDe & !dePrev. dePrev updates only on iPixelEn.
- hCnt counts pixel periods since the last deRise and saturates at H_MAX-1. deRun counts the iDe-high length of the current line.
- Frame start is a deRise with lineTotal != 0 and hCnt > lineTotal + (lineTotal>>1).
- Normal line start is any other deRise. On a normal line start, lineTotal <= hCnt.
- Virtual line counter: hPos runs from frame start and wraps at lineTotal-1. Each wrap increments vPos. vLines counts normal line starts plus 1.
- Frame capture at frame start: capH = deRun of the last active line, capHt = lineTotal, capVa = vLines, capVt = vPos+1. The frame is valid only if hPos == lineTotal-1 at the frame-start sample.
- A captured frame is a mismatch if any line in it had deRun != capH or rise-to-rise != lineTotal.
- States:
  - SEARCH: first deRise clears hCnt. Second deRise loads lineTotal and moves to ACQUIRE.
  - ACQUIRE: at frame start go to VERIFY; matchCnt=0; clear captures.
  - VERIFY: at each frame start, compare the capture against the previous capture. If equal and valid, matchCnt++, else matchCnt=0. Store the capture. When matchCnt reaches LOCK_FRAMES, go to LOCKED and copy the capture to the o* geometry outputs.
  - LOCKED: oLocked=1. Each frame start must reproduce the geometry outputs exactly. Any line-length or active-width mismatch, frame-length mismatch, or invalid frame pulses oLockLost, clears oLocked and matchCnt, and goes to ACQUIRE. The geometry outputs hold their last value.
- hCnt saturation (no deRise within H_MAX periods) in any state goes to SEARCH: lineTotal=0, outputs hold, oLocked=0, oLockLost pulses if previously LOCKED.
- oPixelSync is high for exactly one iClk, the cycle after the frame-start sample. It fires for the frame start that enters LOCKED and for every frame start while LOCKED. It never fires in other states.
- A frame start and a lock loss on the same sample: oLockLost pulses and no oPixelSync.
- Latency: oLocked, the geometry outputs and oPixelSync all register one clock after the qualifying iPixelEn sample.
- iRst mid-frame returns to SEARCH immediately; no pulses are generated.

Test Plan:
- Stream 24x16 active, 32x24 total, iPixelEn every 2nd clock, LOCK_FRAMES=2 -> oLocked rises one clock after the 4th frame start. Geometry outputs read 24/32/16/24. oPixelSync is a 1-clock pulse at the 4th frame start and every frame start after.
- Locked stream, then one line with 23 active pixels -> oLockLost 1-clock pulse, oLocked 0, outputs hold 24/32/16/24, relock after 4 more clean frame starts.
- Locked stream, then iDe held low for 2100 periods (H_MAX=2048) -> state SEARCH, oLocked 0, single oLockLost pulse, no oPixelSync.
- Alternate frames of vTotal 24 and 25 -> oLocked never asserts, oPixelSync never pulses.
- iRst asserted mid-frame while locked -> all outputs 0 asynchronously. After release, lock again after the 4th frame start.
- Generator-in-loop: connect oPixelSync to the local timing generator -> the generator's first active pixel coincides with each received frame's first iDe sample, offset one clock.

Source files
------------

// File: rtl/video_timing_recovery.sv
// Receive-side video timing recovery: measures the geometry of a DE-qualified pixel
// stream, locks after repeated identical frames and emits a frame-start sync pulse.
module video_timing_recovery #(
  parameter int H_MAX       = 2048,
  parameter int V_MAX       = 2048,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iPixelEn,
  input  logic                     iDe,
  output logic                     oPixelSync,
  output logic                     oLocked,
  output logic                     oLockLost,
  output logic [$clog2(H_MAX):0]   oHactive,
  output logic [$clog2(H_MAX):0]   oHtotal,
  output logic [$clog2(V_MAX):0]   oVactive,
  output logic [$clog2(V_MAX):0]   oVtotal
);

  localparam int HW = $clog2(H_MAX) + 1;
  localparam int VW = $clog2(V_MAX) + 1;
  localparam logic [HW-1:0] H_SAT  = HW'(H_MAX - 1);
  localparam logic [VW-1:0] V_SAT  = VW'(V_MAX - 1);
  localparam logic [HW-1:0] H_ONE  = HW'(1);
  localparam logic [VW-1:0] V_ONE  = VW'(1);
  localparam logic [HW-1:0] H_ZERO = {HW{1'b0}};
  localparam logic [VW-1:0] V_ZERO = {VW{1'b0}};
  localparam logic [3:0]    LOCK_N = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    VERIFY  = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic            seen_r, seen_s;
  logic            de_prev_r, de_prev_s;
  logic [HW-1:0]   h_cnt_r, h_cnt_s;
  logic [HW-1:0]   de_run_r, de_run_s;
  logic [HW-1:0]   line_total_r, line_total_s;
  logic [HW-1:0]   h_pos_r, h_pos_s;
  logic [HW-1:0]   run_ref_r, run_ref_s;
  logic [VW-1:0]   v_pos_r, v_pos_s;
  logic [VW-1:0]   v_lines_r, v_lines_s;
  logic            bad_r, bad_s;
  logic [HW-1:0]   cap_h_r, cap_h_s, cap_ht_r, cap_ht_s;
  logic [VW-1:0]   cap_va_r, cap_va_s, cap_vt_r, cap_vt_s;
  logic [3:0]      match_cnt_r, match_cnt_s;
  logic [HW-1:0]   hact_r, hact_s, htot_r, htot_s;
  logic [VW-1:0]   vact_r, vact_s, vtot_r, vtot_s;
  logic            locked_r, locked_s, sync_r, sync_s, lost_r, lost_s;

  logic            de_rise_s, frame_start_s, line_start_s, sat_s;
  logic [HW:0]     h_limit_s;
  logic [VW-1:0]   cur_vt_s;
  logic            cur_valid_s, eq_prev_s, eq_out_s;
  logic [3:0]      match_inc_s;

  // Sample-level events and comparison of the frame just ended against stored geometry
  always_comb begin
    de_rise_s     = iPixelEn & iDe & ~de_prev_r;
    h_limit_s     = {1'b0, line_total_r} + {2'b00, line_total_r[HW-1:1]};
    frame_start_s = de_rise_s && (line_total_r != H_ZERO) && ({1'b0, h_cnt_r} > h_limit_s);
    line_start_s  = de_rise_s && !frame_start_s;
    sat_s         = iPixelEn && !de_rise_s && (h_cnt_r == H_SAT);
    cur_vt_s      = v_pos_r + V_ONE;
    // The last active line must also match the width seen on every earlier line
    cur_valid_s   = (h_pos_r == (line_total_r - H_ONE)) && !bad_r &&
                    !((v_lines_r != V_ONE) && (de_run_r != run_ref_r));
    eq_prev_s     = (de_run_r == cap_h_r) && (line_total_r == cap_ht_r) &&
                    (v_lines_r == cap_va_r) && (cur_vt_s == cap_vt_r);
    eq_out_s      = (de_run_r == hact_r) && (line_total_r == htot_r) &&
                    (v_lines_r == vact_r) && (cur_vt_s == vtot_r);
    match_inc_s   = match_cnt_r + 4'd1;
  end

  // Next-state, measurement counters and output decisions
  always_comb begin
    state_s      = state_r;
    seen_s       = seen_r;
    de_prev_s    = de_prev_r;
    h_cnt_s      = h_cnt_r;
    de_run_s     = de_run_r;
    line_total_s = line_total_r;
    h_pos_s      = h_pos_r;
    v_pos_s      = v_pos_r;
    v_lines_s    = v_lines_r;
    run_ref_s    = run_ref_r;
    bad_s        = bad_r;
    cap_h_s      = cap_h_r;
    cap_ht_s     = cap_ht_r;
    cap_va_s     = cap_va_r;
    cap_vt_s     = cap_vt_r;
    match_cnt_s  = match_cnt_r;
    hact_s       = hact_r;
    htot_s       = htot_r;
    vact_s       = vact_r;
    vtot_s       = vtot_r;
    locked_s     = locked_r;
    sync_s       = 1'b0;
    lost_s       = 1'b0;
    if (iPixelEn) begin
      de_prev_s = iDe;
      if (de_rise_s) h_cnt_s = H_ONE;
      else if (h_cnt_r != H_SAT) h_cnt_s = h_cnt_r + H_ONE;
      else h_cnt_s = h_cnt_r;
      if (de_rise_s) de_run_s = H_ONE;
      else if (iDe && (de_run_r != H_SAT)) de_run_s = de_run_r + H_ONE;
      else de_run_s = de_run_r;
      // Virtual raster position, restarted at every frame start
      if (frame_start_s) begin
        h_pos_s = H_ZERO;
        v_pos_s = V_ZERO;
      end else if (h_pos_r >= (line_total_r - H_ONE)) begin
        h_pos_s = H_ZERO;
        v_pos_s = (v_pos_r != V_SAT) ? (v_pos_r + V_ONE) : v_pos_r;
      end else begin
        h_pos_s = h_pos_r + H_ONE;
      end
      if (frame_start_s) begin
        v_lines_s = V_ONE;
        bad_s     = 1'b0;
      end else if (line_start_s) begin
        v_lines_s = (v_lines_r != V_SAT) ? (v_lines_r + V_ONE) : v_lines_r;
        if (v_lines_r == V_ONE) run_ref_s = de_run_r;
        else run_ref_s = run_ref_r;
        bad_s = bad_r | ((v_lines_r != V_ONE) && (de_run_r != run_ref_r)) |
                (h_cnt_r != line_total_r);
        if (state_r != SEARCH) line_total_s = h_cnt_r;
        else line_total_s = line_total_r;
      end else begin
        v_lines_s = v_lines_r;
      end
      if (sat_s) begin
        state_s      = SEARCH;
        seen_s       = 1'b0;
        line_total_s = H_ZERO;
        match_cnt_s  = 4'd0;
        locked_s     = 1'b0;
        lost_s       = (state_r == LOCKED);
      end else begin
        case (state_r)
          SEARCH: begin
            if (de_rise_s && seen_r) begin
              line_total_s = h_cnt_r;
              seen_s       = 1'b0;
              state_s      = ACQUIRE;
            end else if (de_rise_s) begin
              seen_s = 1'b1;
            end else begin
              seen_s = seen_r;
            end
          end
          ACQUIRE: begin
            if (frame_start_s) begin
              state_s     = VERIFY;
              match_cnt_s = 4'd0;
              cap_h_s     = H_ZERO;
              cap_ht_s    = H_ZERO;
              cap_va_s    = V_ZERO;
              cap_vt_s    = V_ZERO;
            end else begin
              state_s = state_r;
            end
          end
          VERIFY: begin
            if (frame_start_s) begin
              cap_h_s  = de_run_r;
              cap_ht_s = line_total_r;
              cap_va_s = v_lines_r;
              cap_vt_s = cur_vt_s;
              if (cur_valid_s && eq_prev_s) match_cnt_s = match_inc_s;
              else match_cnt_s = 4'd0;
              if (cur_valid_s && eq_prev_s && (match_inc_s == LOCK_N)) begin
                state_s  = LOCKED;
                locked_s = 1'b1;
                sync_s   = 1'b1;
                hact_s   = de_run_r;
                htot_s   = line_total_r;
                vact_s   = v_lines_r;
                vtot_s   = cur_vt_s;
              end else begin
                state_s = state_r;
              end
            end else begin
              state_s = state_r;
            end
          end
          LOCKED: begin
            if (frame_start_s && cur_valid_s && eq_out_s) begin
              sync_s = 1'b1;
            end else if (frame_start_s) begin
              lost_s      = 1'b1;
              locked_s    = 1'b0;
              match_cnt_s = 4'd0;
              state_s     = ACQUIRE;
            end else begin
              state_s = state_r;
            end
          end
          default: state_s = SEARCH;
        endcase
      end
    end else begin
      de_prev_s = de_prev_r;
    end
  end

  // State and measurement registers with asynchronous reset
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_r      <= SEARCH;
      seen_r       <= 1'b0;
      de_prev_r    <= 1'b0;
      h_cnt_r      <= H_ZERO;
      de_run_r     <= H_ZERO;
      line_total_r <= H_ZERO;
      h_pos_r      <= H_ZERO;
      v_pos_r      <= V_ZERO;
      v_lines_r    <= V_ZERO;
      run_ref_r    <= H_ZERO;
      bad_r        <= 1'b0;
      cap_h_r      <= H_ZERO;
      cap_ht_r     <= H_ZERO;
      cap_va_r     <= V_ZERO;
      cap_vt_r     <= V_ZERO;
      match_cnt_r  <= 4'd0;
      hact_r       <= H_ZERO;
      htot_r       <= H_ZERO;
      vact_r       <= V_ZERO;
      vtot_r       <= V_ZERO;
      locked_r     <= 1'b0;
      sync_r       <= 1'b0;
      lost_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      seen_r       <= seen_s;
      de_prev_r    <= de_prev_s;
      h_cnt_r      <= h_cnt_s;
      de_run_r     <= de_run_s;
      line_total_r <= line_total_s;
      h_pos_r      <= h_pos_s;
      v_pos_r      <= v_pos_s;
      v_lines_r    <= v_lines_s;
      run_ref_r    <= run_ref_s;
      bad_r        <= bad_s;
      cap_h_r      <= cap_h_s;
      cap_ht_r     <= cap_ht_s;
      cap_va_r     <= cap_va_s;
      cap_vt_r     <= cap_vt_s;
      match_cnt_r  <= match_cnt_s;
      hact_r       <= hact_s;
      htot_r       <= htot_s;
      vact_r       <= vact_s;
      vtot_r       <= vtot_s;
      locked_r     <= locked_s;
      sync_r       <= sync_s;
      lost_r       <= lost_s;
    end
  end

  assign oPixelSync = sync_r;
  assign oLocked    = locked_r;
  assign oLockLost  = lost_r;
  assign oHactive   = hact_r;
  assign oHtotal    = htot_r;
  assign oVactive   = vact_r;
  assign oVtotal    = vtot_r;

endmodule
